ili9341_controller: RTL and testbench

ILI9341_CONTROLLER -- requirements
Module: ili9341_controller

---
 rtl/ili9341_controller.sv | 165 ++++++++++++++++
 tb/tb_ili9341_controller.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ili9341_controller.sv
// ILI9341 SPI panel controller: power-up init, address window setup and
// continuous RGB565 pixel streaming paced by a pixel-rate strobe.
`default_nettype none

module ili9341_controller #(
   parameter int WAIT_CYCLES = 7_500_000,
   parameter int COLS        = 240,
   parameter int ROWS        = 240
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        frame_done,
   input  logic [15:0] input_data,
   output logic        spi_mosi,
   output logic        spi_sck,
   output logic        spi_cs,
   output logic        spi_dc,
   output logic        data_clk
);
   localparam int WW = ($clog2(WAIT_CYCLES + 1) > 24) ? $clog2(WAIT_CYCLES + 1) : 24;
   localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_CYCLES - 1);
   localparam logic [4:0] LAST_INIT = 5'd6;
   localparam logic [4:0] FIRST_WIN = 5'd7;
   localparam logic [4:0] LAST_WIN  = 5'd17;

   typedef enum logic [2:0] {INIT_CMD, INIT_WAIT, WINDOW, STREAM, FRAME_IDLE} state_t;

   state_t        state_q, state_d;
   logic          run_q, run_d;
   logic [4:0]    cnt_q, cnt_d;
   logic [4:0]    idx_q, idx_d;
   logic [WW-1:0] wait_q, wait_d;
   logic [15:0]   shift_q, shift_d;
   logic          mosi_d, sck_d, cs_d, dc_d, dclk_d;
   logic [7:0]    byte_d;

   // Indices 0-6 are the init bytes, 7-17 the window setup bytes.
   function automatic logic [7:0] seq_byte(input logic [4:0] idx);
      case (idx)
         5'd0:    seq_byte = 8'h01;
         5'd1:    seq_byte = 8'h11;
         5'd2:    seq_byte = 8'h3A;
         5'd3:    seq_byte = 8'h55;
         5'd4:    seq_byte = 8'h36;
         5'd5:    seq_byte = 8'h48;
         5'd6:    seq_byte = 8'h29;
         5'd7:    seq_byte = 8'h2A;
         5'd11:   seq_byte = 8'(COLS - 1);
         5'd12:   seq_byte = 8'h2B;
         5'd16:   seq_byte = 8'(ROWS - 1);
         5'd17:   seq_byte = 8'h2C;
         default: seq_byte = 8'h00;
      endcase
   endfunction

   function automatic logic is_cmd(input logic [4:0] idx);
      is_cmd = (idx inside {5'd0, 5'd1, 5'd2, 5'd4, 5'd6, 5'd7, 5'd12, 5'd17});
   endfunction

   always_comb begin
      state_d = state_q;
      run_d   = 1'b1;
      cnt_d   = cnt_q + 5'd1;
      idx_d   = idx_q;
      wait_d  = wait_q;
      shift_d = shift_q;
      // The first cycle after reset only arms the outputs, so bit 7 of 0x01
      // gets a full cycle A.
      if (!run_q) begin
         cnt_d = 5'd0;
      end else begin
         case (state_q)
            INIT_CMD: if (cnt_q == 5'd15) begin
               cnt_d = 5'd0;
               idx_d = idx_q + 5'd1;
               if (idx_q < 5'd2) begin
                  state_d = INIT_WAIT;
                  wait_d  = '0;
               end else if (idx_q == LAST_INIT) begin
                  state_d = frame_done ? FRAME_IDLE : WINDOW;
               end
            end
            INIT_WAIT: begin
               cnt_d = 5'd0;
               if (wait_q == WAIT_LAST) state_d = INIT_CMD;
               else                     wait_d  = wait_q + 1'b1;
            end
            WINDOW: if (cnt_q == 5'd15) begin
               cnt_d = 5'd0;
               if (idx_q == LAST_WIN) begin
                  state_d = STREAM;
                  shift_d = input_data;
               end else begin
                  idx_d = idx_q + 5'd1;
               end
            end
            STREAM: if (cnt_q == 5'd31) begin
               shift_d = input_data;
               if (frame_done) state_d = FRAME_IDLE;
            end
            FRAME_IDLE: if (cnt_q == 5'd31 && !frame_done) begin
               state_d = WINDOW;
               idx_d   = FIRST_WIN;
            end
            default: state_d = INIT_CMD;
         endcase
      end

      // Outputs are decoded from the next state so they register in step with it.
      byte_d = seq_byte(idx_d);
      mosi_d = 1'b0;
      sck_d  = 1'b0;
      cs_d   = 1'b1;
      dc_d   = 1'b0;
      dclk_d = 1'b0;
      case (state_d)
         INIT_CMD, WINDOW: begin
            cs_d   = 1'b0;
            sck_d  = cnt_d[0];
            mosi_d = byte_d[3'd7 - cnt_d[3:1]];
            dc_d   = ~is_cmd(idx_d);
         end
         STREAM: begin
            cs_d   = 1'b0;
            sck_d  = cnt_d[0];
            mosi_d = shift_d[4'd15 - cnt_d[4:1]];
            dc_d   = 1'b1;
            dclk_d = ~cnt_d[4];
         end
         FRAME_IDLE: dclk_d = ~cnt_d[4];
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= INIT_CMD;
         run_q    <= 1'b0;
         cnt_q    <= 5'd0;
         idx_q    <= 5'd0;
         wait_q   <= '0;
         shift_q  <= 16'h0000;
         spi_mosi <= 1'b0;
         spi_sck  <= 1'b0;
         spi_cs   <= 1'b1;
         spi_dc   <= 1'b0;
         data_clk <= 1'b0;
      end else begin
         state_q  <= state_d;
         run_q    <= run_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         wait_q   <= wait_d;
         shift_q  <= shift_d;
         spi_mosi <= mosi_d;
         spi_sck  <= sck_d;
         spi_cs   <= cs_d;
         spi_dc   <= dc_d;
         data_clk <= dclk_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_ili9341_controller.sv
// Self-checking bench for ili9341_controller: decodes the SPI stream and
// compares it with byte sequences and pixel values predicted by the bench.
`timescale 1ns/1ps
`default_nettype none

module tb_ili9341_controller;
   localparam int WAITC = 10;
   localparam int COLS  = 240;
   localparam int ROWS  = 240;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        frame_done = 1'b0;
   logic [15:0] input_data = 16'hF800;
   logic        spi_mosi, spi_sck, spi_cs, spi_dc, data_clk;

   ili9341_controller #(.WAIT_CYCLES(WAITC), .COLS(COLS), .ROWS(ROWS)) dut (
      .clk(clk), .rst(rst), .frame_done(frame_done), .input_data(input_data),
      .spi_mosi(spi_mosi), .spi_sck(spi_sck), .spi_cs(spi_cs),
      .spi_dc(spi_dc), .data_clk(data_clk)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Decoded bytes as {dc, byte}, chip-select high runs and data_clk timing.
   logic [8:0] rx_q[$];
   int         cs_runs[$];
   int         period_q[$];
   int         high_q[$];
   int         cyc = 0, nb = 0, cs_hi = 0, last_rise = -1, cs_fall_gap = -1;
   bit         seen_low = 0;
   logic       prev_sck = 1'b0, prev_dclk = 1'b0;
   logic [7:0] sh = 8'h00;

   logic [8:0] exp_init[7];
   logic [8:0] exp_win[11];

   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         rx_q.delete(); cs_runs.delete(); period_q.delete(); high_q.delete();
         nb = 0; cs_hi = 0; last_rise = -1; cs_fall_gap = -1; seen_low = 0;
      end else begin
         if (spi_cs) nb = 0;
         else if (spi_sck && !prev_sck) begin
            sh = {sh[6:0], spi_mosi};
            nb++;
            if (nb == 8) begin
               rx_q.push_back({spi_dc, sh});
               nb = 0;
            end
         end
         if (spi_cs) begin
            if (seen_low) cs_hi++;
         end else begin
            if (seen_low && cs_hi > 0) begin
               cs_runs.push_back(cs_hi);
               cs_fall_gap = cyc - last_rise;
            end
            cs_hi = 0;
            seen_low = 1;
         end
         if (data_clk && !prev_dclk) begin
            if (last_rise >= 0) period_q.push_back(cyc - last_rise);
            last_rise = cyc;
         end
         if (!data_clk && prev_dclk && last_rise >= 0) high_q.push_back(cyc - last_rise);
      end
      prev_sck  = spi_sck;
      prev_dclk = data_clk;
   end

   task automatic wait_rx(input int n, input int budget, output bit ok);
      int t = 0;
      while (rx_q.size() < n && t < budget) begin
         @(negedge clk);
         t++;
      end
      ok = (rx_q.size() >= n);
   endtask

   task automatic wait_rise(output bit ok);
      logic last;
      last = data_clk;
      ok = 0;
      for (int t = 0; t < 100 && !ok; t++) begin
         @(posedge clk);
         #1;
         if (data_clk && !last) ok = 1;
         last = data_clk;
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_checks++;
      if ({spi_cs, spi_sck, spi_mosi, spi_dc, data_clk} !== 5'b10000) begin
         n_fail++;
         $display("FAIL reset_outputs: got cs,sck,mosi,dc,dclk=%b required 10000",
                  {spi_cs, spi_sck, spi_mosi, spi_dc, data_clk});
      end
      rst = 1'b1;
   endtask

   task automatic test_init();
      bit ok;
      wait_rx(7, 400, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL init_timeout: got %0d bytes required 7", rx_q.size());
      end else begin
         for (int i = 0; i < 7; i++) begin
            n_checks++;
            if (rx_q[i] !== exp_init[i]) begin
               n_fail++;
               $display("FAIL init_byte%0d: got dc/byte %h required %h", i, rx_q[i], exp_init[i]);
            end
         end
      end
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (cs_runs.size() <= i || cs_runs[i] !== WAITC) begin
            n_fail++;
            $display("FAIL init_wait%0d: got cs-high run %0d required %0d", i,
                     (cs_runs.size() > i) ? cs_runs[i] : -1, WAITC);
         end
      end
   endtask

   task automatic test_window();
      bit ok;
      wait_rx(18, 400, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL window_timeout: got %0d bytes required 18", rx_q.size());
      end else begin
         for (int i = 0; i < 11; i++) begin
            n_checks++;
            if (rx_q[7 + i] !== exp_win[i]) begin
               n_fail++;
               $display("FAIL window_byte%0d: got dc/byte %h required %h", i, rx_q[7 + i], exp_win[i]);
            end
         end
      end
   endtask

   task automatic test_pixels();
      bit ok;
      wait_rx(26, 400, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL pixel_timeout: got %0d bytes required 26", rx_q.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (rx_q[18 + i] !== ((i % 2 == 0) ? 9'h1F8 : 9'h100)) begin
               n_fail++;
               $display("FAIL const_pixel_byte%0d: got dc/byte %h required %h", i,
                        rx_q[18 + i], (i % 2 == 0) ? 9'h1F8 : 9'h100);
            end
         end
      end
      n_checks++;
      if (period_q.size() < 2 || high_q.size() < 2) begin
         n_fail++;
         $display("FAIL dclk_seen: got %0d periods required at least 2", period_q.size());
      end
      foreach (period_q[i]) begin
         n_checks++;
         if (period_q[i] !== 32) begin
            n_fail++;
            $display("FAIL dclk_period%0d: got %0d required 32", i, period_q[i]);
         end
      end
      foreach (high_q[i]) begin
         n_checks++;
         if (high_q[i] !== 16) begin
            n_fail++;
            $display("FAIL dclk_high%0d: got %0d required 16", i, high_q[i]);
         end
      end
   endtask

   task automatic test_counting();
      logic [15:0] exp_q[$];
      logic [15:0] v, got;
      bit ok;
      exp_q.push_back(input_data);
      for (int i = 0; i < 8; i++) begin
         wait_rise(ok);
         n_checks++;
         if (!ok) begin
            n_fail++;
            $display("FAIL count_rise%0d: got no data_clk rise required one", i);
         end
         if (i == 0) rx_q.delete();
         v = 16'($urandom);
         input_data = v;
         exp_q.push_back(v);
      end
      wait_rx(16, 200, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL count_timeout: got %0d bytes required 16", rx_q.size());
      end else begin
         for (int j = 0; j < 8; j++) begin
            got = {rx_q[2*j][7:0], rx_q[2*j+1][7:0]};
            n_checks++;
            if (got !== exp_q[j] || rx_q[2*j][8] !== 1'b1 || rx_q[2*j+1][8] !== 1'b1) begin
               n_fail++;
               $display("FAIL count_pixel%0d: got %h dc=%b%b required %h dc=11", j, got,
                        rx_q[2*j][8], rx_q[2*j+1][8], exp_q[j]);
            end
         end
      end
   endtask

   task automatic test_frame_done();
      bit ok;
      int t, p0;
      wait_rise(ok);
      rx_q.delete();
      repeat ($urandom_range(1, 28)) @(negedge clk);
      frame_done = 1'b1;
      t = 0;
      while (!spi_cs && t < 64) begin
         @(negedge clk);
         t++;
      end
      n_checks++;
      if (!spi_cs) begin
         n_fail++;
         $display("FAIL fd_cs_timeout: got cs=0 required 1");
      end
      n_checks++;
      if (rx_q.size() != 2 || rx_q[0][8] !== 1'b1 || rx_q[1][8] !== 1'b1) begin
         n_fail++;
         $display("FAIL fd_pixel_complete: got %0d bytes required 2 data bytes", rx_q.size());
      end
      n_checks++;
      if (data_clk !== 1'b1) begin
         n_fail++;
         $display("FAIL fd_boundary: got data_clk=%b at cs rise required 1", data_clk);
      end
      p0 = period_q.size();
      repeat (128) @(negedge clk);
      n_checks++;
      if (period_q.size() - p0 < 3 || spi_cs !== 1'b1 || rx_q.size() != 2) begin
         n_fail++;
         $display("FAIL fd_idle: got %0d new periods cs=%b bytes=%0d required >=3 1 2",
                  period_q.size() - p0, spi_cs, rx_q.size());
      end
      rx_q.delete();
      repeat ($urandom_range(0, 31)) @(negedge clk);
      frame_done = 1'b0;
      wait_rx(11, 200, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL fd_rewindow_timeout: got %0d bytes required 11", rx_q.size());
      end else begin
         for (int i = 0; i < 11; i++) begin
            n_checks++;
            if (rx_q[i] !== exp_win[i]) begin
               n_fail++;
               $display("FAIL rewindow_byte%0d: got dc/byte %h required %h", i, rx_q[i], exp_win[i]);
            end
         end
      end
      n_checks++;
      if (cs_fall_gap !== 32) begin
         n_fail++;
         $display("FAIL rewindow_align: got cs fall %0d cycles after dclk rise required 32", cs_fall_gap);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      repeat ($urandom_range(3, 60)) @(negedge clk);
      rst = 1'b0;
      #1;
      n_checks++;
      if ({spi_cs, spi_sck, spi_mosi, spi_dc, data_clk} !== 5'b10000) begin
         n_fail++;
         $display("FAIL midreset_outputs: got cs,sck,mosi,dc,dclk=%b required 10000",
                  {spi_cs, spi_sck, spi_mosi, spi_dc, data_clk});
      end
      frame_done = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      wait_rx(7, 400, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL midreset_timeout: got %0d bytes required 7", rx_q.size());
      end else begin
         for (int i = 0; i < 7; i++) begin
            n_checks++;
            if (rx_q[i] !== exp_init[i]) begin
               n_fail++;
               $display("FAIL midreset_byte%0d: got dc/byte %h required %h", i, rx_q[i], exp_init[i]);
            end
         end
      end
      repeat (150) @(negedge clk);
      n_checks++;
      if (rx_q.size() != 7 || spi_cs !== 1'b1 || period_q.size() < 3) begin
         n_fail++;
         $display("FAIL init_to_idle: got bytes=%0d cs=%b periods=%0d required 7 1 >=3",
                  rx_q.size(), spi_cs, period_q.size());
      end
   endtask

   initial begin
      exp_init = '{9'h001, 9'h011, 9'h03A, 9'h155, 9'h036, 9'h148, 9'h029};
      exp_win  = '{9'h02A, 9'h100, 9'h100, 9'h100, {1'b1, 8'(COLS - 1)},
                   9'h02B, 9'h100, 9'h100, 9'h100, {1'b1, 8'(ROWS - 1)}, 9'h02C};
      test_reset();
      test_init();
      test_window();
      test_pixels();
      test_counting();
      test_frame_done();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
